// File: rtl/ft232h_sync245_emu.sv
// Device-side model of an FT232H in 245-synchronous FIFO mode: two byte FIFOs bridge
// the sync245 pins to valid/ready host streams, with sticky protocol-violation flags.
module ft232h_sync245_emu #(
  parameter int RX_AW          = 4,
  parameter int TX_AW          = 4,
  parameter int STARTUP_CYCLES = 8
) (
  input  logic       ft_clkout,
  input  logic       rst,
  input  logic       ft_oen,
  input  logic       ft_rdn,
  input  logic       ft_wrn,
  input  logic       ft_siwun,
  input  logic       ft_pwrsavn,
  input  logic [7:0] ft_data_in,
  output logic       ft_rxfn,
  output logic       ft_txen,
  output logic [7:0] ft_data_out,
  output logic       ft_data_out_enable,
  input  logic [7:0] host_rx_data,
  input  logic       host_rx_valid,
  output logic       host_rx_ready,
  output logic [7:0] host_tx_data,
  output logic       host_tx_valid,
  input  logic       host_tx_ready,
  output logic       host_flush,
  output logic       err_rd_no_oe,
  output logic       err_wr_during_oe,
  output logic       err_overrun
);

  localparam logic [7:0]     START_INIT = 8'(STARTUP_CYCLES);
  localparam logic [RX_AW:0] RX_FULL    = {1'b1, {RX_AW{1'b0}}};
  localparam logic [TX_AW:0] TX_FULL    = {1'b1, {TX_AW{1'b0}}};
  localparam logic [RX_AW:0] RX_ONE     = {{RX_AW{1'b0}}, 1'b1};
  localparam logic [TX_AW:0] TX_ONE     = {{TX_AW{1'b0}}, 1'b1};

  logic [7:0]     r_rx_mem [1<<RX_AW];
  logic [7:0]     r_tx_mem [1<<TX_AW];
  logic [RX_AW:0] r_rx_wr, r_rx_rd;
  logic [TX_AW:0] r_tx_wr, r_tx_rd;
  logic [7:0]     r_start;
  logic           r_oen_prev, r_siwu_prev, r_flush;
  logic           r_err_rd, r_err_wr, r_err_ov;

  logic           w_active;
  logic [RX_AW:0] w_rx_count;
  logic [TX_AW:0] w_tx_count;
  logic           w_rx_full, w_tx_full;
  logic           w_rx_pop, w_rx_push, w_tx_pop, w_tx_push;
  logic           w_tx_swap, w_overrun;

  assign w_active   = (r_start == 8'd0) && ft_pwrsavn;
  assign w_rx_count = r_rx_wr - r_rx_rd;
  assign w_tx_count = r_tx_wr - r_tx_rd;
  assign w_rx_full  = (w_rx_count == RX_FULL);
  assign w_tx_full  = (w_tx_count == TX_FULL);

  assign ft_rxfn            = !(w_active && (w_rx_count != '0));
  assign ft_txen            = !(w_active && !w_tx_full);
  assign ft_data_out        = r_rx_mem[r_rx_rd[RX_AW-1:0]];
  assign ft_data_out_enable = !ft_oen;
  assign host_rx_ready      = w_active && !w_rx_full;
  assign host_tx_valid      = (w_tx_count != '0);
  assign host_tx_data       = r_tx_mem[r_tx_rd[TX_AW-1:0]];
  assign host_flush         = r_flush;
  assign err_rd_no_oe       = r_err_rd;
  assign err_wr_during_oe   = r_err_wr;
  assign err_overrun        = r_err_ov;

  // A write into a full TX FIFO is still taken when the host frees a slot on the same edge.
  assign w_rx_pop  = !ft_rdn && !ft_oen && !ft_rxfn;
  assign w_rx_push = host_rx_valid && host_rx_ready;
  assign w_tx_pop  = host_tx_valid && host_tx_ready;
  assign w_tx_swap = w_active && w_tx_full && w_tx_pop;
  assign w_tx_push = !ft_wrn && (!ft_txen || w_tx_swap);
  assign w_overrun = (!ft_wrn && !w_tx_push) || (!ft_rdn && ft_rxfn);

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge ft_clkout) begin
    if (w_rx_push) r_rx_mem[r_rx_wr[RX_AW-1:0]] <= host_rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wr[TX_AW-1:0]] <= ft_data_in;
  end

  // Pointers, startup/power-save counter, edge history and sticky error flags.
  always_ff @(posedge ft_clkout or posedge rst) begin
    if (rst) begin
      r_rx_wr     <= '0;
      r_rx_rd     <= '0;
      r_tx_wr     <= '0;
      r_tx_rd     <= '0;
      r_start     <= START_INIT;
      r_oen_prev  <= 1'b1;
      r_siwu_prev <= 1'b1;
      r_flush     <= 1'b0;
      r_err_rd    <= 1'b0;
      r_err_wr    <= 1'b0;
      r_err_ov    <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + RX_ONE;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + RX_ONE;
      if (w_tx_push) r_tx_wr <= r_tx_wr + TX_ONE;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + TX_ONE;
      if (!ft_pwrsavn)
        r_start <= START_INIT;
      else if (r_start != 8'd0)
        r_start <= r_start - 8'd1;
      r_oen_prev  <= ft_oen;
      r_siwu_prev <= ft_siwun;
      r_flush     <= r_siwu_prev && !ft_siwun;
      if (!ft_rdn && r_oen_prev) r_err_rd <= 1'b1;
      if (!ft_wrn && !ft_oen)    r_err_wr <= 1'b1;
      if (w_overrun)             r_err_ov <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ft232h_sync245_emu.sv
// Self-checking bench for ft232h_sync245_emu: directed protocol steps then random traffic,
// all compared against a queue-based model of the chip's FIFO and flag rules.
module tb_ft232h_sync245_emu;

  logic       ft_clkout = 1'b0;
  logic       rst;
  logic       ft_oen, ft_rdn, ft_wrn, ft_siwun, ft_pwrsavn;
  logic [7:0] ft_data_in;
  logic       ft_rxfn, ft_txen, ft_data_out_enable;
  logic [7:0] ft_data_out;
  logic [7:0] host_rx_data, host_tx_data;
  logic       host_rx_valid, host_rx_ready, host_tx_valid, host_tx_ready;
  logic       host_flush, err_rd_no_oe, err_wr_during_oe, err_overrun;

  int total = 0;
  int bad   = 0;

  always #5 ft_clkout = ~ft_clkout;

  ft232h_sync245_emu #(.RX_AW(4), .TX_AW(4), .STARTUP_CYCLES(8)) dut (
    .ft_clkout(ft_clkout), .rst(rst), .ft_oen(ft_oen), .ft_rdn(ft_rdn), .ft_wrn(ft_wrn),
    .ft_siwun(ft_siwun), .ft_pwrsavn(ft_pwrsavn), .ft_data_in(ft_data_in),
    .ft_rxfn(ft_rxfn), .ft_txen(ft_txen), .ft_data_out(ft_data_out),
    .ft_data_out_enable(ft_data_out_enable), .host_rx_data(host_rx_data),
    .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid),
    .host_tx_ready(host_tx_ready), .host_flush(host_flush), .err_rd_no_oe(err_rd_no_oe),
    .err_wr_during_oe(err_wr_during_oe), .err_overrun(err_overrun)
  );

  // Reference model: byte queues plus the few scalars the chip remembers.
  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  int         m_st;
  logic       m_oen_prev, m_siwu_prev, m_flush, m_e_rd, m_e_wr, m_e_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rx.delete();
    m_tx.delete();
    m_st        = 8;
    m_oen_prev  = 1'b1;
    m_siwu_prev = 1'b1;
    m_flush     = 1'b0;
    m_e_rd      = 1'b0;
    m_e_wr      = 1'b0;
    m_e_ov      = 1'b0;
  endtask

  task automatic idle();
    ft_oen = 1'b1; ft_rdn = 1'b1; ft_wrn = 1'b1; ft_siwun = 1'b1;
    host_rx_valid = 1'b0; host_tx_ready = 1'b0;
  endtask

  task automatic check_all();
    logic act;
    act = (m_st == 0) && ft_pwrsavn;
    chk("rxfn", ft_rxfn, !(act && m_rx.size() != 0));
    chk("txen", ft_txen, !(act && m_tx.size() != 16));
    chk("host_rx_ready", host_rx_ready, act && m_rx.size() < 16);
    chk("host_tx_valid", host_tx_valid, m_tx.size() != 0);
    if (m_tx.size() != 0) chk("host_tx_data", host_tx_data, m_tx[0]);
    if (m_rx.size() != 0) chk("ft_data_out", ft_data_out, m_rx[0]);
    chk("data_out_enable", ft_data_out_enable, !ft_oen);
    chk("host_flush", host_flush, m_flush);
    chk("err_rd_no_oe", err_rd_no_oe, m_e_rd);
    chk("err_wr_during_oe", err_wr_during_oe, m_e_wr);
    chk("err_overrun", err_overrun, m_e_ov);
  endtask

  // One clock: decide model events from pre-edge inputs, take the edge, then compare.
  task automatic tick();
    logic act, rxfn_m, txen_m, rpop, tpop, tpush, hpush, ov;
    act    = (m_st == 0) && ft_pwrsavn;
    rxfn_m = !(act && m_rx.size() != 0);
    txen_m = !(act && m_tx.size() != 16);
    rpop   = !ft_rdn && !ft_oen && !rxfn_m;
    tpop   = host_tx_ready && m_tx.size() != 0;
    tpush  = !ft_wrn && (!txen_m || (act && m_tx.size() == 16 && tpop));
    hpush  = host_rx_valid && act && m_rx.size() < 16;
    ov     = (!ft_wrn && !tpush) || (!ft_rdn && rxfn_m);
    @(posedge ft_clkout);
    if (rpop)  void'(m_rx.pop_front());
    if (tpop)  void'(m_tx.pop_front());
    if (tpush) m_tx.push_back(ft_data_in);
    if (hpush) m_rx.push_back(host_rx_data);
    if (!ft_rdn && m_oen_prev) m_e_rd = 1'b1;
    if (!ft_wrn && !ft_oen)    m_e_wr = 1'b1;
    if (ov)                    m_e_ov = 1'b1;
    m_flush     = m_siwu_prev && !ft_siwun;
    m_siwu_prev = ft_siwun;
    m_oen_prev  = ft_oen;
    if (!ft_pwrsavn)   m_st = 8;
    else if (m_st > 0) m_st = m_st - 1;
    #1;
    check_all();
  endtask

  initial begin
    int flushes;
    rst = 1'b1; ft_pwrsavn = 1'b1; ft_data_in = 8'h00; host_rx_data = 8'h00;
    idle();
    model_reset();
    #12;
    chk("reset_rxfn", ft_rxfn, 1'b1);
    chk("reset_txen", ft_txen, 1'b1);
    chk("reset_tx_valid", host_tx_valid, 1'b0);
    chk("reset_rx_ready", host_rx_ready, 1'b0);
    chk("reset_flush", host_flush, 1'b0);
    chk("reset_errs", {err_rd_no_oe, err_wr_during_oe, err_overrun}, 3'b000);
    @(posedge ft_clkout); #1;
    rst = 1'b0;

    // Startup hold: flags high for 8 cycles, TXE# low on the 9th.
    chk("startup_txen_c1", ft_txen, 1'b1);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("startup_txen", ft_txen, 1'b1);
      chk("startup_rxfn", ft_rxfn, 1'b1);
    end
    tick();
    chk("startup_txen_c9", ft_txen, 1'b0);

    host_rx_valid = 1'b1; host_rx_data = 8'h11; tick();
    chk("rxfn_after_first_push", ft_rxfn, 1'b0);
    host_rx_data = 8'h22; tick();
    host_rx_valid = 1'b0;
    ft_oen = 1'b0; tick();
    ft_rdn = 1'b0; tick(); tick();
    idle(); tick();

    // Host sends A5,5A; FPGA reads them with OE# leading RD# by one cycle.
    host_rx_valid = 1'b1; host_rx_data = 8'hA5; tick();
    host_rx_data = 8'h5A; tick();
    host_rx_valid = 1'b0;
    ft_oen = 1'b0; tick();
    ft_rdn = 1'b0;
    chk("read_first", ft_data_out, 8'hA5);
    tick();
    chk("read_second", ft_data_out, 8'h5A);
    tick();
    chk("rxfn_after_last_pop", ft_rxfn, 1'b1);
    idle(); tick();
    chk("no_errors_yet", {err_rd_no_oe, err_wr_during_oe, err_overrun}, 3'b000);

    // Fill TX with 0x00..0x0F while the host stalls, then one overrun write.
    ft_wrn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ft_data_in = 8'(i);
      tick();
    end
    chk("txen_full", ft_txen, 1'b1);
    ft_data_in = 8'hEE; tick();
    chk("overrun_set", err_overrun, 1'b1);
    ft_oen = 1'b0; tick();
    chk("wr_during_oe_set", err_wr_during_oe, 1'b1);
    idle(); tick();

    // Full FIFO: host pop and FPGA write 0x99 on the same edge.
    host_tx_ready = 1'b1; ft_wrn = 1'b0; ft_data_in = 8'h99;
    chk("drain_0", host_tx_data, 8'h00);
    tick();
    chk("swap_txen", ft_txen, 1'b1);
    chk("swap_valid", host_tx_valid, 1'b1);
    ft_wrn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", host_tx_data, (i == 16) ? 8'h99 : 8'(i));
      tick();
    end
    chk("tx_empty", host_tx_valid, 1'b0);
    idle(); tick();

    // RD# with OE# high on the previous cycle.
    ft_rdn = 1'b0; tick();
    chk("rd_no_oe_set", err_rd_no_oe, 1'b1);
    idle(); tick();

    // SIWU# low for three cycles gives one flush pulse.
    flushes = 0;
    ft_siwun = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) ft_siwun = 1'b1;
      tick();
      if (host_flush) flushes++;
    end
    chk("flush_count", flushes, 1);

    // Power-save mid-stream keeps data and replays the startup hold.
    host_rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_rx_data = 8'($urandom);
      tick();
    end
    host_rx_valid = 1'b0;
    ft_wrn = 1'b0; ft_data_in = 8'($urandom); tick();
    ft_wrn = 1'b1;
    ft_pwrsavn = 1'b0; tick();
    chk("pwrsav_rxfn", ft_rxfn, 1'b1);
    chk("pwrsav_txen", ft_txen, 1'b1);
    tick(); tick();
    ft_pwrsavn = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("resume_hold_rxfn", ft_rxfn, 1'b1);
    end
    tick();
    chk("resume_rxfn", ft_rxfn, 1'b0);
    chk("resume_txen", ft_txen, 1'b0);
    ft_oen = 1'b0; tick();
    ft_rdn = 1'b0;
    for (int i = 0; i < 16 && m_rx.size() != 0; i++) tick();
    idle(); host_tx_ready = 1'b1; tick(); tick();
    idle(); tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ft_pwrsavn    = ($urandom_range(0, 29) != 0);
      ft_oen        = $urandom_range(0, 1) != 0;
      ft_rdn        = $urandom_range(0, 2) != 0;
      ft_wrn        = $urandom_range(0, 1) != 0;
      ft_siwun      = $urandom_range(0, 7) != 0;
      ft_data_in    = 8'($urandom);
      host_rx_valid = $urandom_range(0, 1) != 0;
      host_rx_data  = 8'($urandom);
      host_tx_ready = $urandom_range(0, 2) == 0;
      tick();
    end
    idle(); ft_pwrsavn = 1'b1; tick();
    chk("errs_sticky", {err_rd_no_oe, err_wr_during_oe, err_overrun}, 3'b111);

    // Asynchronous reset in the middle of traffic discards everything.
    host_rx_valid = 1'b1; host_rx_data = 8'h3C; ft_wrn = 1'b0; ft_data_in = 8'hC3;
    for (int i = 0; i < 12; i++) tick();
    idle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_rxfn", ft_rxfn, 1'b1);
    chk("midrst_txen", ft_txen, 1'b1);
    chk("midrst_tx_valid", host_tx_valid, 1'b0);
    chk("midrst_errs", {err_rd_no_oe, err_wr_during_oe, err_overrun}, 3'b000);
    @(posedge ft_clkout); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("post_reset_empty_rxfn", ft_rxfn, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ft232h_sync245_emu.md
Name: ft232h_sync245_emu

Overview:
- Synthesizable device-side model of the FT232H in 245-synchronous FIFO mode: the chip end of the FPGA's sync245 bridge.
- It drives RXF#/TXE#/read data and honours OE#/RD#/WR#/SIWU#/PWRSAV# exactly as the FPGA bridge expects.
- Its "USB host" side is a pair of valid/ready byte streams.
- Used for loopback builds and as the DUT partner in bridge testbenches; includes sticky protocol-violation flags.

Parameters:
- RX_AW, 4, log2 depth of host->FPGA FIFO (16 bytes).
- TX_AW, 4, log2 depth of FPGA->host FIFO (16 bytes).
- STARTUP_CYCLES, 8, cycles after reset/power-up during which RXF# and TXE# are held high (1..255).

Ports:
- ft_clkout  input  1  sole clock (60 MHz CLKOUT domain); all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- ft_oen  input  1  OE#, low = chip drives data bus
- ft_rdn  input  1  RD#, low at edge = consume head byte
- ft_wrn  input  1  WR#, low at edge = accept byte
- ft_siwun  input  1  SIWU#, low at edge = flush request
- ft_pwrsavn  input  1  PWRSAV#, low = suspended
- ft_data_in  input  8  bus value driven by FPGA
- ft_rxfn  output  1  RXF#, low = read data available
- ft_txen  output  1  TXE#, low = space for write
- ft_data_out  output  8  RX FIFO head byte
- ft_data_out_enable  output  1  chip drives bus
- host_rx_data  input  8  byte from host
- host_rx_valid  input  1  host byte offered
- host_rx_ready  output  1  RX FIFO not full
- host_tx_data  output  8  byte to host
- host_tx_valid  output  1  TX FIFO not empty
- host_tx_ready  input  1  host accepts byte
- host_flush  output  1  one-cycle pulse per SIWU# falling edge
- err_rd_no_oe  output  1  sticky: RD# low while OE# was high on the previous cycle
- err_wr_during_oe  output  1  sticky: WR# low while OE# low
- err_overrun  output  1  sticky: WR# low while TXE# high, or RD# low while RXF# high

Behaviour:
- Reset (async):
  - FIFOs empty; startup counter = STARTUP_CYCLES.
  - ft_rxfn=1, ft_txen=1, host_tx_valid=0, host_flush=0, all err=0.
  - host_rx_ready=0 until the startup counter reaches 0.
  - Reset mid-transfer discards all FIFO contents.
- active = (startup counter==0) && ft_pwrsavn.
  - Startup counter decrements once per cycle while ft_pwrsavn=1.
  - It reloads to STARTUP_CYCLES on any cycle with ft_pwrsavn=0.
- Flags are pure functions of registered state, so they update the cycle after the edge that changes occupancy:
  - ft_rxfn = !(active && rx_count!=0).
  - ft_txen = !(active && tx_count!=(1<<TX_AW)).
- Read path:
  - ft_data_out = RX head, combinational from registers; ft_data_out_enable = !ft_oen.
  - Pop at an edge when !ft_rdn && !ft_oen && !ft_rxfn; the FPGA captures the byte in that same cycle.
  - The last byte read deasserts RXF# on the next cycle; a back-to-back RD# after that is not a pop.
- Write path:
  - Push ft_data_in at an edge when !ft_wrn && !ft_txen.
  - A write that fills the FIFO raises TXE# on the next cycle.
- Host side:
  - RX push when host_rx_valid && host_rx_ready; host_rx_ready = active && rx not full.
  - TX pop when host_tx_valid && host_tx_ready; host_tx_valid = tx not empty; host_tx_data = TX head.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle are both honoured; count is unchanged.
  - A full FIFO popped and pushed in the same cycle is legal.
- Pointers are RX_AW+1 / TX_AW+1 bits with wrap bit; count = wr-rd modulo 2^(AW+1).
- host_flush: register previous ft_siwun; pulse when prev=1 && current=0.
- Error flags set on the offending edge and clear only on reset. Offending accesses are ignored:
  - no push/pop on overrun;
  - no pop without OE# low on the current cycle.
- err_rd_no_oe:
  - Uses registered oen_prev; ft_rdn low with oen_prev=1 sets the flag.
  - The pop still occurs if OE# is low in the current cycle, flags permitting.

Test Plan:
- Reset release, ft_pwrsavn=1, STARTUP_CYCLES=8 -> ft_rxfn/ft_txen stay 1 for exactly 8 cycles, ft_txen=0 on cycle 9; host pushes 0x11,0x22 -> ft_rxfn=0 one cycle after first push.
- Host pushes 0xA5,0x5A; FPGA drives OE# low 1 cycle, then RD# low 2 cycles -> ft_data_out reads 0xA5 then 0x5A; ft_rxfn=1 the cycle after the second pop; no error flags set.
- FPGA writes 16 bytes 0x00..0x0F with host_tx_ready=0 -> ft_txen=1 after the 16th; a 17th WR# sets err_overrun and is dropped; host drains 0x00..0x0F in order.
- FIFO full; host pops and FPGA writes 0x99 in the same cycle -> count stays 16, ft_txen stays 1, 0x99 emerges last.
- RD# low with OE# high the previous cycle -> err_rd_no_oe=1; WR# low while OE# low -> err_wr_during_oe=1; both remain set until rst.
- SIWU# pulsed low 3 cycles -> exactly one host_flush pulse; ft_pwrsavn=0 mid-stream -> ft_rxfn=ft_txen=1 next cycle, data retained, flags return STARTUP_CYCLES after PWRSAV# rises.
